// File: rtl/regfile_dump_pkg.sv
// Shared definitions for the register-file dump engine.
//   state_e   : dump FSM states (IDLE, STREAM)
//   NUM_REGS  : architectural register count
//   IDX_W     : beat index / counter width
//   CKSUM_IDX : beat index carrying the checksum
//   LAST_IDX  : index of the final beat of a dump
// Optional feature: define REGFILE_DUMP_CHECKSUM_EN to append a 33rd checksum beat.
package regfile_dump_pkg;

  typedef enum logic [0:0] {
    IDLE,
    STREAM
  } state_e;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned IDX_W    = 6;

  localparam logic [IDX_W-1:0] CKSUM_IDX = 6'd32;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam logic [IDX_W-1:0] LAST_IDX = CKSUM_IDX;
`else
  localparam logic [IDX_W-1:0] LAST_IDX = 6'd31;
`endif

endpackage : regfile_dump_pkg

// File: rtl/regfile_dump_snapshot.sv
// Capture buffer for the register-file dump.
// Loads the whole register file in one cycle (x0 forced to zero) and exposes a
// combinational indexed read.
//   clk       : clock
//   load      : capture regfile_i into the snapshot this cycle
//   regfile_i : live register-file contents
//   rd_idx    : beat index to read
//   rd_data   : snapshot word at rd_idx (checksum at CKSUM_IDX when enabled)
// Optional feature: REGFILE_DUMP_CHECKSUM_EN adds the XOR checksum register,
// folded at capture time so the extra beat needs no extra latency.
module regfile_dump_snapshot #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic                               clk,
  input  logic                               load,
  input  logic [WIDTH-1:0]                   regfile_i [NUM_REGS],
  input  logic [regfile_dump_pkg::IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0]                   rd_data
);
  import regfile_dump_pkg::*;

  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [WIDTH-1:0] snap_q [NUM_REGS];

  // x0 is not reset in the register file, so its live value is meaningless.
  logic [WIDTH-1:0] unused_x0;
  assign unused_x0 = regfile_i[0];

  always_ff @(posedge clk) begin
    if (load) begin
      snap_q[0] <= '0;
      for (int i = 1; i < NUM_REGS; i++) begin
        snap_q[i] <= regfile_i[i];
      end
    end
  end

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [WIDTH-1:0] cksum_d;
  logic [WIDTH-1:0] cksum_q;

  // x0 contributes zero, so it is simply left out of the fold.
  always_comb begin
    cksum_d = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      cksum_d = cksum_d ^ regfile_i[i];
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      cksum_q <= cksum_d;
    end
  end

  always_comb begin
    rd_data = snap_q[rd_idx[AW-1:0]];
    if (rd_idx == CKSUM_IDX) begin
      rd_data = cksum_q;
    end
  end
`else
  // The index never exceeds NUM_REGS-1 without the checksum beat.
  logic unused_idx_msb;
  assign unused_idx_msb = rd_idx[IDX_W-1];

  assign rd_data = snap_q[rd_idx[AW-1:0]];
`endif

endmodule : regfile_dump_snapshot

// File: rtl/regfile_dump.sv
// Debug read-out engine for the 32x32 integer register file.
// On an accepted request it snapshots every register in one cycle, then
// streams one register per beat over a valid/ready interface while the core
// keeps running.
//   clk, rst   : clock, synchronous active-high reset
//   regfile_i  : live register-file contents
//   req_valid  : dump request (held by the requester until req_ready)
//   req_pc     : PC tagged onto the dump
//   req_ready  : engine idle, request accepted this cycle
//   out_valid  : beat valid
//   out_ready  : sink accepts the beat
//   out_idx    : register index of the beat (32 for the checksum beat)
//   out_data   : register value or checksum
//   out_pc     : captured req_pc
//   out_last   : final beat of the dump
//   busy       : dump in progress
// Optional feature: REGFILE_DUMP_CHECKSUM_EN appends an XOR checksum beat.
module regfile_dump #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] regfile_i [NUM_REGS],
  input  logic             req_valid,
  input  logic [31:0]      req_pc,
  output logic             req_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_idx,
  output logic [WIDTH-1:0] out_data,
  output logic [31:0]      out_pc,
  output logic             out_last,
  output logic             busy
);
  import regfile_dump_pkg::*;

  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic [31:0]      pc_q;
  logic             load;
  logic [WIDTH-1:0] rd_data;
  logic             at_last;

  assign load    = (state_q == IDLE) && req_valid && !rst;
  assign at_last = (cnt_q == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            pc_q    <= req_pc;
            cnt_q   <= '0;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready) begin
            if (at_last) begin
              // Park the counter at zero so out_idx idles at its reset value.
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  regfile_dump_snapshot #(
    .WIDTH    (WIDTH),
    .NUM_REGS (NUM_REGS)
  ) u_snapshot (
    .clk       (clk),
    .load      (load),
    .regfile_i (regfile_i),
    .rd_idx    (cnt_q),
    .rd_data   (rd_data)
  );

  assign req_ready = (state_q == IDLE);
  assign busy      = ~req_ready;
  assign out_valid = (state_q == STREAM);
  assign out_idx   = cnt_q;
  // Snapshot contents are undefined until the first capture; keep data quiet.
  assign out_data  = out_valid ? rd_data : '0;
  assign out_pc    = pc_q;
  assign out_last  = out_valid && at_last;

endmodule : regfile_dump

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: the driver pushes expected beats when it
// issues a request, a negedge monitor pops and compares on every handshake.
module tb_regfile_dump;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int NB = 33;
`else
  localparam int NB = 32;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rf [32];
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_idx;
  logic [31:0] out_data;
  logic [31:0] out_pc;
  logic        out_last;
  logic        busy;

  always #5 clk = ~clk;

  regfile_dump #(
    .WIDTH    (32),
    .NUM_REGS (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .regfile_i (rf),
    .req_valid (req_valid),
    .req_pc    (req_pc),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .out_pc    (out_pc),
    .out_last  (out_last),
    .busy      (busy)
  );

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] data;
    logic [31:0] pc;
    logic        last;
  } beat_t;

  beat_t       sb [$];
  logic [31:0] exp_vals [32];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          accepts  = 0;
  logic        gap_arm  = 1'b0;
  logic        gap_pending = 1'b0;
  int          last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_dump(input logic [31:0] pc, input int nbeats);
    beat_t       b;
    logic [31:0] x;
    x = '0;
    for (int i = 0; i < 32; i++) begin
      x      = x ^ exp_vals[i];
      b.idx  = 6'(i);
      b.data = exp_vals[i];
      b.pc   = pc;
      b.last = (NB == 32) && (i == 31);
      if (i < nbeats) sb.push_back(b);
    end
    if (NB == 33 && nbeats == 33) begin
      b.idx  = 6'd32;
      b.data = x;
      b.pc   = pc;
      b.last = 1'b1;
      sb.push_back(b);
    end
  endtask

  // Monitor: handshakes, stall stability, turnaround and accept counting.
  initial begin
    beat_t e;
    beat_t held;
    logic  held_v;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        if (req_valid && req_ready) accepts++;
        if (held_v) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_idx", 32'(out_idx), 32'(held.idx));
          check("stall_data", out_data, held.data);
          check("stall_last", 32'(out_last), 32'(held.last));
          held_v = 1'b0;
        end
        if (out_valid) begin
          if (gap_pending) begin
            check("turnaround", 32'(cyc - last_cyc), 32'd2);
            check("restart_idx", 32'(out_idx), 32'd0);
            gap_pending = 1'b0;
            gap_arm     = 1'b0;
          end
          if (out_ready) begin
            if (sb.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_beat: got idx %0d expected no beat", out_idx);
            end else begin
              e = sb.pop_front();
              check("beat_idx", 32'(out_idx), 32'(e.idx));
              check("beat_data", out_data, e.data);
              check("beat_pc", out_pc, e.pc);
              check("beat_last", 32'(out_last), 32'(e.last));
              if (e.last && gap_arm) begin
                gap_pending = 1'b1;
                last_cyc    = cyc;
              end
            end
          end else begin
            held_v    = 1'b1;
            held.idx  = out_idx;
            held.data = out_data;
            held.pc   = out_pc;
            held.last = out_last;
          end
        end
      end
    end
  end

  task automatic pulse(input logic [31:0] pc);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_pc    = pc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_idle(input bit stall, input string name);
    bit done;
    bit pat [4];
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
    done = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      out_ready = stall ? pat[c % 4] : 1'b1;
      if (sb.size() == 0 && req_ready) begin
        done = 1'b1;
        break;
      end
    end
    out_ready = 1'b1;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got %0d pending beats expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic load_base(input logic [31:0] base, input logic [31:0] step);
    for (int i = 0; i < 32; i++) begin
      rf[i]       = base + step * 32'(i);
      exp_vals[i] = (i == 0) ? 32'h0 : base + step * 32'(i);
    end
    rf[0] = 32'hFFFF_FFFF;
  endtask

  initial begin
    int base;
    bit hit;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_pc    = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_idx", 32'(out_idx), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);

    // Basic dump; x0 driven all-ones, x5 overwritten right after capture.
    load_base(32'h1000_0000, 32'd1);
    push_dump(32'h8000_0040, NB);
    pulse(32'h8000_0040);
    rf[5] = 32'hDEAD_BEEF;
    run_idle(1'b0, "basic");

    // Stalled sink with a 1,0,0,1 ready pattern.
    load_base(32'h0300_0000, 32'h0001_0101);
    push_dump(32'h8000_1000, NB);
    pulse(32'h8000_1000);
    run_idle(1'b1, "stall");

    // Back-to-back dumps with req_valid held high.
    load_base(32'h1000_0000, 32'd1);
    push_dump(32'h8000_0100, NB);
    push_dump(32'h8000_0100, NB);
    gap_arm = 1'b1;
    base    = accepts;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_pc    = 32'h8000_0100;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (accepts >= base + 2) break;
    end
    req_valid = 1'b0;
    run_idle(1'b0, "b2b");
    check("gap_seen", 32'(gap_arm), 32'd0);
    gap_arm     = 1'b0;
    gap_pending = 1'b0;

    // Reset while beat 10 is presented.
    push_dump(32'h8000_0200, 10);
    pulse(32'h8000_0200);
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (out_valid && out_idx == 6'd10) begin
        hit = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("rst_reach_beat10", 32'(hit), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_last", 32'(out_last), 32'd0);
    check("abort_out_idx", 32'(out_idx), 32'd0);
    check("abort_out_data", out_data, 32'd0);
    check("abort_out_pc", out_pc, 32'd0);
    check("abort_sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();

    push_dump(32'h8000_0300, NB);
    pulse(32'h8000_0300);
    run_idle(1'b0, "restart");

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_regfile_dump
